// File: rtl/lcd_text_ctrl_if.sv
// lcd_text_ctrl_if: host-write port and LCD pin bundle for lcd_text_ctrl.
//   wr_en/wr_addr/wr_char : buffer write, one cell per cycle (cell = row*COLS+col)
//   clr                   : one-cycle pulse, fills the buffer with 0x20
//   lcd_en/rw/rs/data     : HD44780 pins (rw tied 0, data latched on en fall)
//   init_done             : sticky, set once the init sequence completes
//   frame_done            : one-cycle pulse at the end of each full refresh
// Modports: master = host/bench side, slave = controller side.
interface lcd_text_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic              clr;
  logic              lcd_en;
  logic              lcd_rw;
  logic              lcd_rs;
  logic [7:0]        lcd_data;
  logic              init_done;
  logic              frame_done;

  modport master (
    output wr_en, wr_addr, wr_char, clr,
    input  lcd_en, lcd_rw, lcd_rs, lcd_data, init_done, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, clr,
    output lcd_en, lcd_rw, lcd_rs, lcd_data, init_done, frame_done
  );
endinterface

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780-compatible character LCD controller with a
// host-writable ROWS x COLS text buffer. After PWRUP cycles it runs a fixed
// init sequence, then refreshes the whole buffer row by row forever.
// Every bus transfer is one STEP-cycle step: rs/data registered at step
// start, lcd_en high for the first STEP/2 cycles, low for the rest.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lcd_text_ctrl_if.slave (host writes in, LCD pins out)
//
// Build option: define LCD_NIBBLE_MODE_EN for a 4-bit bus (each byte sent
// as high then low nibble on lcd_data[7:4], 0x3/0x3/0x3/0x2 wake-up prefix,
// function set 0x28). Undefined: 8-bit bus.
module lcd_text_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int PWRUP_US = 20_000,
  parameter int STEP_US  = 2_000,
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int ADDR_W   = 7
) (
  input logic            clk,
  input logic            rst_n,
  lcd_text_ctrl_if.slave bus
);

  localparam int PWRUP = CLK_HZ / 1_000_000 * PWRUP_US;
  localparam int STEP  = CLK_HZ / 1_000_000 * STEP_US;
  localparam int CELLS = ROWS * COLS;
  localparam int TMAX  = (PWRUP > STEP) ? PWRUP : STEP;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW_C  = (CELLS > 1) ? $clog2(CELLS) : 1;

`ifdef LCD_NIBBLE_MODE_EN
  localparam bit       NIBBLE    = 1'b1;
  localparam bit [3:0] INIT_LAST = 4'd8;
`else
  localparam bit       NIBBLE    = 1'b0;
  localparam bit [3:0] INIT_LAST = 4'd4;
`endif

  localparam logic [TW-1:0] PWRUP_T  = TW'(PWRUP);
  localparam logic [TW-1:0] STEP_T   = TW'(STEP - 1);
  localparam logic [TW-1:0] HALF_T   = TW'(STEP / 2 - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {S_PWRUP, S_INIT, S_ROW_ADDR, S_CHAR} state_t;

  // Descriptor of the step currently on the bus.
  typedef struct packed {
    state_t        st;
    logic [3:0]    idx;   // init step index
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          half;  // nibble mode: 1 = low-nibble step
  } cur_t;

  localparam cur_t CUR_RST = '{st: S_PWRUP, idx: 4'd0, row: '0, col: '0, half: 1'b0};

  function automatic logic [7:0] init_byte(input logic [3:0] i);
    logic [7:0] b;
`ifdef LCD_NIBBLE_MODE_EN
    // Steps 0..3 are single-nibble wake-up steps carried in the high nibble.
    case (i)
      4'd0, 4'd1, 4'd2: b = 8'h30;
      4'd3:             b = 8'h20;
      4'd4:             b = 8'h28;
      4'd5:             b = 8'h08;
      4'd6:             b = 8'h01;
      4'd7:             b = 8'h06;
      default:          b = 8'h0C;
    endcase
`else
    case (i)
      4'd0:    b = 8'h38;
      4'd1:    b = 8'h08;
      4'd2:    b = 8'h01;
      4'd3:    b = 8'h06;
      default: b = 8'h0C;
    endcase
`endif
    return b;
  endfunction

  function automatic logic [7:0] row_base(input logic [RW-1:0] r);
    logic [7:0] b;
    case (int'(r))
      0:       b = 8'h00;
      1:       b = 8'h40;
      2:       b = 8'h14;
      default: b = 8'h54;
    endcase
    return b;
  endfunction

  // ---------------- display buffer ----------------
  logic [CELLS-1:0][7:0] mem;
  logic [ADDR_W-1:0]     waddr;
  logic [AW_C-1:0]       widx;

  assign waddr = bus.wr_addr;
  assign widx  = AW_C'(waddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= {CELLS{8'h20}};
    end else if (bus.clr) begin
      mem <= {CELLS{8'h20}};                    // clear wins over a same-cycle write
    end else if (bus.wr_en && (int'(waddr) < CELLS)) begin
      mem[widx] <= bus.wr_char;
    end
  end

  // ---------------- sequencer ----------------
  cur_t          cur, nx;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          en_q, en_n, rs_q, rs_n, init_q, init_n;
  logic [7:0]    data_q, data_n, byte_n;
  logic [AW_C-1:0] rd_idx;
  logic          step_start, nib_only, last_char;
`ifdef LCD_NIBBLE_MODE_EN
  // Low nibble is latched with the high nibble so both halves of a
  // character come from the same buffer sample.
  logic [3:0]    lo_q, lo_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= CUR_RST;
      tcnt   <= '0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      init_q <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
      lo_q   <= 4'h0;
`endif
    end else begin
      cur    <= nx;
      tcnt   <= tcnt_n;
      en_q   <= en_n;
      rs_q   <= rs_n;
      data_q <= data_n;
      init_q <= init_n;
`ifdef LCD_NIBBLE_MODE_EN
      lo_q   <= lo_n;
`endif
    end
  end

  always_comb begin
    nx         = cur;
    tcnt_n     = tcnt + 1'b1;
    en_n       = en_q;
    rs_n       = rs_q;
    data_n     = data_q;
    init_n     = init_q;
    byte_n     = 8'h00;
    rd_idx     = '0;
    step_start = 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
    lo_n       = lo_q;
`endif
    nib_only   = NIBBLE && (cur.st == S_INIT) && (cur.idx < 4'd4);
    last_char  = (cur.st == S_CHAR) && (cur.col == COL_LAST) &&
                 (cur.row == ROW_LAST) && (!NIBBLE || cur.half);

    if (cur.st == S_PWRUP) begin
      if (tcnt == PWRUP_T) begin
        step_start = 1'b1;
        nx.st      = S_INIT;
        nx.idx     = 4'd0;
        nx.half    = 1'b0;
      end
    end else begin
      if (tcnt == HALF_T) en_n = 1'b0;
      if (tcnt == STEP_T) begin
        step_start = 1'b1;
        if (NIBBLE && !cur.half && !nib_only) begin
          nx.half = 1'b1;
        end else begin
          nx.half = 1'b0;
          unique case (cur.st)
            S_INIT: begin
              if (cur.idx == INIT_LAST) begin
                nx.st  = S_ROW_ADDR;
                nx.row = '0;
                nx.col = '0;
                init_n = 1'b1;
              end else begin
                nx.idx = cur.idx + 4'd1;
              end
            end
            S_ROW_ADDR: begin
              nx.st  = S_CHAR;
              nx.col = '0;
            end
            S_CHAR: begin
              if (cur.col == COL_LAST) begin
                nx.st  = S_ROW_ADDR;
                nx.col = '0;
                nx.row = (cur.row == ROW_LAST) ? '0 : cur.row + 1'b1;
              end else begin
                nx.col = cur.col + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end

    // Load the next step's bus values; buffer cell sampled here.
    if (step_start) begin
      tcnt_n = '0;
      en_n   = 1'b1;
      rd_idx = AW_C'(int'(nx.row) * COLS + int'(nx.col));
      case (nx.st)
        S_INIT: begin
          byte_n = init_byte(nx.idx);
          rs_n   = 1'b0;
        end
        S_ROW_ADDR: begin
          byte_n = 8'h80 | row_base(nx.row);
          rs_n   = 1'b0;
        end
        default: begin
          byte_n = mem[rd_idx];
          rs_n   = 1'b1;
        end
      endcase
`ifdef LCD_NIBBLE_MODE_EN
      if (nx.half) begin
        data_n = {lo_q, 4'h0};
      end else begin
        data_n = {byte_n[7:4], 4'h0};
        lo_n   = byte_n[3:0];
      end
`else
      data_n = byte_n;
`endif
    end
  end

  assign bus.lcd_en     = en_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_data   = data_q;
  assign bus.init_done  = init_q;
  assign bus.frame_done = last_char && (tcnt == STEP_T);

endmodule
